// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache fills and dcache fills/write-backs share
// one line-wide memory port, round-robin granted, with a wait timeout.
// Ports:
//   clk, reset (async, active-low)
//   ic_req/ic_addr -> ic_ack/ic_err/ic_rdata        icache line fills
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_ack/dc_err/dc_rdata   dcache
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rdata   memory
//   owner: 00 idle, 01 icache, 10 dcache
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic              ic_err,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic              dc_err,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [1:0]        owner
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ACK  = 2'b10
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              last_dc, last_dc_n;
    logic              pick_dc;
    logic              ic_ack_n, ic_err_n, dc_ack_n, dc_err_n;
    logic [LINE_W-1:0] ic_rdata_n, dc_rdata_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [LINE_W-1:0] mem_wdata_n;
    logic [1:0]        owner_n;

    // dcache wins unless both request and dcache had the previous grant
    assign pick_dc = dc_req && !(ic_req && last_dc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_dc   <= 1'b0;
            ic_ack    <= 1'b0;
            ic_err    <= 1'b0;
            ic_rdata  <= '0;
            dc_ack    <= 1'b0;
            dc_err    <= 1'b0;
            dc_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 2'b00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last_dc   <= last_dc_n;
            ic_ack    <= ic_ack_n;
            ic_err    <= ic_err_n;
            ic_rdata  <= ic_rdata_n;
            dc_ack    <= dc_ack_n;
            dc_err    <= dc_err_n;
            dc_rdata  <= dc_rdata_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            owner     <= owner_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_dc_n   = last_dc;
        ic_ack_n    = 1'b0;
        ic_err_n    = 1'b0;
        dc_ack_n    = 1'b0;
        dc_err_n    = 1'b0;
        ic_rdata_n  = ic_rdata;
        dc_rdata_n  = dc_rdata;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        owner_n     = owner;
        unique case (state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    state_n   = BUSY;
                    cnt_n     = '0;
                    mem_req_n = 1'b1;
                    last_dc_n = pick_dc;
                    if (pick_dc) begin
                        mem_we_n    = dc_we;
                        mem_addr_n  = dc_addr;
                        mem_wdata_n = dc_wdata;
                        owner_n     = 2'b10;
                    end else begin
                        mem_we_n   = 1'b0;
                        mem_addr_n = ic_addr;
                        owner_n    = 2'b01;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt + CW'(1);
                // mem_ready is tested first so it beats a same-cycle timeout
                if (mem_ready || cnt == LAST_CNT) begin
                    state_n   = ACK;
                    mem_req_n = 1'b0;
                    if (owner == 2'b10) begin
                        dc_ack_n = 1'b1;
                        dc_err_n = !mem_ready;
                        if (mem_ready && !mem_we)
                            dc_rdata_n = mem_rdata;
                    end else begin
                        ic_ack_n = 1'b1;
                        ic_err_n = !mem_ready;
                        if (mem_ready)
                            ic_rdata_n = mem_rdata;
                    end
                end
            end
            ACK: begin
                state_n = IDLE;
                owner_n = 2'b00;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic         clk;
    logic         reset;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_ack, ic_err;
    logic [127:0] ic_rdata;
    logic         dc_req, dc_we;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_ack, dc_err;
    logic [127:0] dc_rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic [1:0]   owner;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_ack(ic_ack), .ic_err(ic_err), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_ack(dc_ack), .dc_err(dc_err),
        .dc_rdata(dc_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: who holds the port, how long it has
    // waited, and whether this is its completion cycle.
    int           cur;      // 0 none, 1 icache, 2 dcache
    int           age;      // cycles waited since grant
    bit           closing;
    bit           prev_dc;
    logic         e_ic_ack, e_ic_err, e_dc_ack, e_dc_err;
    logic [127:0] e_ic_rdata, e_dc_rdata;
    logic         e_mem_req, e_mem_we;
    logic [31:0]  e_mem_addr;
    logic [127:0] e_mem_wdata;
    logic [1:0]   e_owner;

    task automatic model_reset();
        cur = 0; age = 0; closing = 0; prev_dc = 0;
        e_ic_ack = 0; e_ic_err = 0; e_dc_ack = 0; e_dc_err = 0;
        e_ic_rdata = '0; e_dc_rdata = '0;
        e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
        e_owner = 2'b00;
    endtask

    task automatic model_step();
        bit take_dc;
        if (!reset) begin
            model_reset();
            return;
        end
        e_ic_ack = 0; e_ic_err = 0; e_dc_ack = 0; e_dc_err = 0;
        if (closing) begin
            closing = 0;
            cur = 0;
            e_owner = 2'b00;
        end else if (cur == 0) begin
            if (ic_req || dc_req) begin
                if (ic_req && dc_req) take_dc = !prev_dc;
                else take_dc = dc_req;
                prev_dc = take_dc;
                age = 0;
                e_mem_req = 1;
                if (take_dc) begin
                    cur = 2; e_owner = 2'b10;
                    e_mem_we = dc_we; e_mem_addr = dc_addr;
                    e_mem_wdata = dc_wdata;
                end else begin
                    cur = 1; e_owner = 2'b01;
                    e_mem_we = 0; e_mem_addr = ic_addr;
                end
            end
        end else begin
            age++;
            if (mem_ready || age == TO) begin
                closing = 1;
                e_mem_req = 0;
                if (cur == 2) begin
                    e_dc_ack = 1; e_dc_err = !mem_ready;
                    if (mem_ready && !e_mem_we) e_dc_rdata = mem_rdata;
                end else begin
                    e_ic_ack = 1; e_ic_err = !mem_ready;
                    if (mem_ready) e_ic_rdata = mem_rdata;
                end
            end
        end
    endtask

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic compare_all();
        check("ic_ack", 128'(ic_ack), 128'(e_ic_ack));
        check("ic_err", 128'(ic_err), 128'(e_ic_err));
        check("ic_rdata", ic_rdata, e_ic_rdata);
        check("dc_ack", 128'(dc_ack), 128'(e_dc_ack));
        check("dc_err", 128'(dc_err), 128'(e_dc_err));
        check("dc_rdata", dc_rdata, e_dc_rdata);
        check("mem_req", 128'(mem_req), 128'(e_mem_req));
        check("owner", 128'(owner), 128'(e_owner));
        if (e_mem_req) begin
            check("mem_we", 128'(mem_we), 128'(e_mem_we));
            check("mem_addr", 128'(mem_addr), 128'(e_mem_addr));
            check("mem_wdata", mem_wdata, e_mem_wdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    bit stall;
    bit was_req;

    initial begin
        reset = 0; ic_req = 0; ic_addr = '0;
        dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        model_reset();
        #3;
        compare_all();
        check("rst_owner", 128'(owner), 128'(2'b00));
        check("rst_mem_req", 128'(mem_req), 128'(1'b0));
        tick(); tick();
        reset = 1;

        // single icache fill
        ic_req = 1; ic_addr = 32'h40;
        tick();
        check("fill_req", 128'(mem_req), 128'(1'b1));
        check("fill_addr", 128'(mem_addr), 128'h40);
        check("fill_we", 128'(mem_we), 128'(1'b0));
        check("fill_owner", 128'(owner), 128'(2'b01));
        repeat (3) tick();
        mem_ready = 1; mem_rdata = {16{8'hA5}};
        tick();
        check("fill_ack", 128'(ic_ack), 128'(1'b1));
        check("fill_err", 128'(ic_err), 128'(1'b0));
        check("fill_rdata", ic_rdata, {16{8'hA5}});
        ic_req = 0; mem_ready = 0;
        tick();
        check("fill_idle", 128'(owner), 128'(2'b00));

        // contention straight after reset: dcache first
        async_reset();
        tick();
        reset = 1;
        ic_req = 1; ic_addr = 32'h80;
        dc_req = 1; dc_we = 0; dc_addr = 32'hC0; dc_wdata = '0;
        tick();
        check("rr_owner1", 128'(owner), 128'(2'b10));
        check("rr_addr1", 128'(mem_addr), 128'hC0);
        mem_ready = 1; mem_rdata = 128'hBEEF;
        tick();
        check("rr_dc_ack", 128'(dc_ack), 128'(1'b1));
        check("rr_owner_ack", 128'(owner), 128'(2'b10));
        check("rr_dc_rdata", dc_rdata, 128'hBEEF);
        dc_req = 0; mem_ready = 0;
        tick();
        check("rr_owner2", 128'(owner), 128'(2'b00));
        tick();
        check("rr_owner3", 128'(owner), 128'(2'b01));
        check("rr_addr3", 128'(mem_addr), 128'h80);
        mem_ready = 1; mem_rdata = 128'h5555;
        tick();
        check("rr_ic_ack", 128'(ic_ack), 128'(1'b1));
        ic_req = 0; mem_ready = 0;
        tick();

        // dcache write-back leaves dc_rdata alone
        dc_req = 1; dc_we = 1; dc_addr = 32'h100; dc_wdata = 128'h1234;
        tick();
        check("wb_we", 128'(mem_we), 128'(1'b1));
        check("wb_addr", 128'(mem_addr), 128'h100);
        check("wb_wdata", mem_wdata, 128'h1234);
        mem_ready = 1; mem_rdata = 128'hDEAD;
        tick();
        check("wb_ack", 128'(dc_ack), 128'(1'b1));
        check("wb_err", 128'(dc_err), 128'(1'b0));
        check("wb_rdata", dc_rdata, 128'hBEEF);
        dc_req = 0; dc_we = 0; mem_ready = 0;
        tick();

        // timeout: ack+err on the 9th cycle after grant
        ic_req = 1; ic_addr = 32'h200;
        tick();
        for (int k = 2; k <= TO; k++) begin
            tick();
            check("to_wait_ack", 128'(ic_ack), 128'(1'b0));
            check("to_wait_req", 128'(mem_req), 128'(1'b1));
        end
        tick();
        check("to_ack", 128'(ic_ack), 128'(1'b1));
        check("to_err", 128'(ic_err), 128'(1'b1));
        check("to_req", 128'(mem_req), 128'(1'b0));
        check("to_rdata", ic_rdata, 128'h5555);
        ic_req = 0;
        tick();
        check("to_after", 128'(mem_req), 128'(1'b0));

        // ready on the timeout cycle wins
        ic_req = 1; ic_addr = 32'h240;
        tick();
        repeat (TO - 1) tick();
        mem_ready = 1; mem_rdata = 128'h77;
        tick();
        check("tie_ack", 128'(ic_ack), 128'(1'b1));
        check("tie_err", 128'(ic_err), 128'(1'b0));
        check("tie_rdata", ic_rdata, 128'h77);
        ic_req = 0; mem_ready = 0;
        tick();

        // reset while busy
        dc_req = 1; dc_we = 0; dc_addr = 32'h300;
        tick();
        check("rb_req", 128'(mem_req), 128'(1'b1));
        async_reset();
        check("rb_async_req", 128'(mem_req), 128'(1'b0));
        check("rb_async_own", 128'(owner), 128'(2'b00));
        mem_ready = 1;
        tick();
        check("rb_no_ack", 128'(dc_ack), 128'(1'b0));
        reset = 1; mem_ready = 0;
        tick();
        check("rb_regrant", 128'(owner), 128'(2'b10));
        check("rb_addr", 128'(mem_addr), 128'h300);
        mem_ready = 1; mem_rdata = 128'h99;
        tick();
        check("rb_ack", 128'(dc_ack), 128'(1'b1));
        dc_req = 0; mem_ready = 0;
        tick();

        // randomized traffic
        stall = 0; was_req = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (ic_ack) ic_req = 0;
            else if (!ic_req && $urandom_range(3) == 0) begin
                ic_req = 1; ic_addr = $urandom;
            end
            if (dc_ack) dc_req = 0;
            else if (!dc_req && $urandom_range(3) == 0) begin
                dc_req = 1; dc_we = $urandom_range(1) == 1;
                dc_addr = $urandom;
                dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mem_req && !was_req) stall = $urandom_range(5) == 0;
            was_req = mem_req;
            if (mem_req) mem_ready = !stall && $urandom_range(2) == 0;
            else mem_ready = $urandom_range(3) == 0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(299) == 0) begin
                async_reset();
                tick();
                reset = 1;
                was_req = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of every address port.
REQ-002 Parameter: LINE_W, 128, cache-line width of every data port.
REQ-003 Parameter: TIMEOUT, 64, maximum cycles waited for mem_ready before abort (min 2).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ic_req  in  1  icache line-fill request, held until ic_ack.
REQ-008 ic_addr  in  ADDR_W  icache line address, stable while ic_req high.
REQ-009 ic_ack  out  1  one-cycle completion pulse to icache.
REQ-010 ic_err  out  1  one-cycle timeout flag, coincident with ic_ack.
REQ-011 ic_rdata  out  LINE_W  fill data, valid while ic_ack high.
REQ-012 dc_req  in  1  dcache fill or write-back request, held until dc_ack.
REQ-013 dc_we  in  1  1 = write-back, 0 = fill; stable while dc_req high.
REQ-014 dc_addr  in  ADDR_W  dcache line address.
REQ-015 dc_wdata  in  LINE_W  write-back data.
REQ-016 dc_ack  out  1  one-cycle completion pulse to dcache.
REQ-017 dc_err  out  1  one-cycle timeout flag, coincident with dc_ack.
REQ-018 dc_rdata  out  LINE_W  fill data, valid while dc_ack high.
REQ-019 mem_req  out  1  memory transaction active.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  ADDR_W  memory line address.
REQ-022 mem_wdata  out  LINE_W  memory write data.
REQ-023 mem_ready  in  1  one-cycle completion from memory; mem_rdata valid the same cycle.
REQ-024 mem_rdata  in  LINE_W  memory read data.
REQ-025 owner  out  2  00 idle, 01 icache, 10 dcache.

Function
REQ-026 FSM states are IDLE, BUSY and ACK; all outputs are registered.
REQ-027 In IDLE with any req high at a rising edge: go to BUSY; latch the winner's addr, we and wdata onto mem_addr, mem_we and mem_wdata; set mem_req=1 and owner.
REQ-028 Icache requests always drive mem_we=0.
REQ-029 Arbitration is round-robin: with both reqs high, grant the requester not granted last; a single requester is granted immediately.
REQ-030 In BUSY with mem_ready high: go to ACK; pulse the owner's ack; capture mem_rdata into the owner's rdata on reads only; set mem_req=0.
REQ-031 A wait counter clears on entry to BUSY and increments each BUSY cycle.
REQ-032 Timeout: when the counter reaches TIMEOUT-1 without mem_ready, go to ACK with the owner's ack=1 and err=1, rdata unchanged, and mem_req=0.
REQ-033 Timeout check order: if mem_ready and timeout occur in the same cycle, mem_ready wins and err=0.
REQ-034 ACK lasts exactly one cycle, then the FSM returns to IDLE and owner=00.
REQ-035 Requests are not sampled in BUSY or ACK; the requester must drop req at the edge ending ACK.
REQ-036 mem_ready is ignored in IDLE and ACK.
REQ-037 Minimum turnaround is req to mem_req in 1 cycle, and mem_ready to ack in 1 cycle.
REQ-038 On dcache write-back, dc_rdata holds its previous value.
REQ-039 The last-grant pointer updates on every grant, including grants that end in timeout.

Reset
REQ-040 Asserting reset (low) immediately forces the FSM to IDLE, clears all ack, err, mem_req, mem_we and owner outputs, zeroes rdata, addr, wdata and the counter, and sets last-grant = icache.
REQ-041 Reset mid-transaction drops the transaction with no ack; after release, the arbiter re-arbitrates from IDLE.

Verification
REQ-042 Single fill: ic_req with ic_addr=0x40; mem_ready 3 cycles after mem_req, mem_rdata=0xA5..A5 -> mem_req=1, mem_addr=0x40, mem_we=0; one cycle after mem_ready, ic_ack=1 and ic_rdata=0xA5..A5.
REQ-043 Contention from reset: ic_req and dc_req rise together -> dcache served first; icache is granted in the IDLE cycle after dcache's ACK; owner sequence is 10,00,01.
REQ-044 Write-back: dc_req with dc_we=1, dc_addr=0x100, dc_wdata=0x1234 -> mem_we=1, mem_addr=0x100, mem_wdata=0x1234; dc_ack pulses and dc_rdata is unchanged.
REQ-045 Timeout: mem_ready never asserted, TIMEOUT=8 -> ack and err pulse together on the 9th cycle after grant, mem_req=0 from then on.
REQ-046 Reset mid-BUSY: assert reset while mem_req=1 -> mem_req=0 and owner=00 without waiting for a clock edge, no ack is issued, and a held req is re-granted after reset release.
